// File: rtl/sdram_prbs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_prbs_pkg
// Description : Shared definitions for the SDRAM PRBS generator/checker:
//               checker state encoding, default polynomial and seed, and the
//               Galois-LFSR step function used by both the generator and the
//               checker's expected-word register.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_prbs_pkg;

    // Checker synchronisation states
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    // x^8+x^4+x^3+x^2+1 with the implicit x^8 term left out
    localparam logic [63:0] c_default_poly = 64'h1D;
    localparam logic [63:0] c_default_seed = 64'd32;

    // One Galois step on the low 'width' bits of s. Callers zero-extend their
    // state to 64 bits and cast the result back to their own width.
    function automatic logic [63:0] prbs_step(
        input logic [63:0] s,
        input logic [63:0] poly,
        input int          width
    );
        logic [63:0] mask;
        logic [63:0] r;
        mask = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        r    = s << 1;
        if (s[6'(width - 1)]) begin
            r = r ^ poly;
        end
        return r & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_prbs_lfsr_core.sv
`default_nettype none
// ============================================================================
// Module      : sdram_prbs_lfsr_core
// Description : WIDTH-bit Galois LFSR register with seed / load / hold / step
//               controls. Priority: reset > i_seed > i_load > i_hold > step.
//               A zero load value is replaced by SEED so the register never
//               enters the lock-up state.
// Ports       : clk, reset   - clock, synchronous active-high reset
//               i_seed       - force state to SEED
//               i_load       - load i_ldata (SEED if i_ldata is zero)
//               i_ldata      - load value
//               i_hold       - keep current state
//               o_state      - current state (the register itself)
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_prbs_lfsr_core
    import sdram_prbs_pkg::*;
#(
    parameter int          WIDTH = 8,
    parameter logic [63:0] POLY  = c_default_poly,
    parameter logic [63:0] SEED  = c_default_seed
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_seed,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_ldata,
    input  logic             i_hold,
    output logic [WIDTH-1:0] o_state
);

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] w_seed;
    logic [WIDTH-1:0] w_step;

    assign w_seed = WIDTH'(SEED);
    assign w_step = WIDTH'(prbs_step(64'(r_state), POLY, WIDTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= w_seed;
        end else if (i_seed) begin
            r_state <= w_seed;
        end else if (i_load) begin
            r_state <= (i_ldata == '0) ? w_seed : i_ldata;
        end else if (!i_hold) begin
            r_state <= w_step;
        end
    end

    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/sdram_prbs_gen_check.sv
`default_nettype none
// ============================================================================
// Module      : sdram_prbs_gen_check
// Description : PRBS write-data generator plus self-synchronising read-back
//               checker. The checker hunts for a nonzero word, predicts the
//               next word, and after LOCK_CNT consecutive matches declares
//               lock. While locked each mismatch pulses o_err and bumps a
//               saturating counter; UNLOCK_CNT consecutive misses drop lock.
// Ports       : clk, reset                  - clock, sync active-high reset
//               i_enable                    - 0: gen to SEED, checker to HUNT
//               i_pause, i_load, i_ldata    - generator controls
//               o_data                      - generator output
//               i_chk_valid, i_chk_data     - read-back word to check
//               i_err_clr                   - clear o_err_count
//               o_chk_lock, o_err, o_err_count - checker status
//               i_inj (SDRAM_PRBS_ERR_INJECT_EN only) - flip bit 0 of the
//                                             next generated word
// Config      : define SDRAM_PRBS_ERR_INJECT_EN to add the error-inject port.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_prbs_gen_check
    import sdram_prbs_pkg::*;
#(
    parameter int          WIDTH      = 8,
    parameter logic [63:0] POLY       = c_default_poly,
    parameter logic [63:0] SEED       = c_default_seed,
    parameter int          LOCK_CNT   = 4,
    parameter int          UNLOCK_CNT = 3,
    parameter int          ERR_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
`ifdef SDRAM_PRBS_ERR_INJECT_EN
    input  logic             i_inj,
`endif
    input  logic             i_enable,
    input  logic             i_pause,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_ldata,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_chk_valid,
    input  logic [WIDTH-1:0] i_chk_data,
    input  logic             i_err_clr,
    output logic             o_chk_lock,
    output logic             o_err,
    output logic [ERR_W-1:0] o_err_count
);

    localparam int c_match_w = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
    localparam int c_miss_w  = (UNLOCK_CNT > 1) ? $clog2(UNLOCK_CNT) : 1;
    localparam logic [c_match_w-1:0] c_match_max = c_match_w'(LOCK_CNT - 1);
    localparam logic [c_miss_w-1:0]  c_miss_max  = c_miss_w'(UNLOCK_CNT - 1);

    // ------------------------------------------------------------------ gen
    logic [WIDTH-1:0] w_gen_state;

    sdram_prbs_lfsr_core #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_gen (
        .clk     (clk),
        .reset   (reset),
        .i_seed  (!i_enable),
        .i_load  (i_load),
        .i_ldata (i_ldata),
        .i_hold  (i_pause),
        .o_state (w_gen_state)
    );

`ifdef SDRAM_PRBS_ERR_INJECT_EN
    // The flip is applied on the output only, so the LFSR sequence survives.
    logic w_gen_adv;
    logic r_inj_flip;

    assign w_gen_adv = i_enable & ~i_load & ~i_pause;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_inj_flip <= 1'b0;
        end else begin
            r_inj_flip <= i_inj & w_gen_adv;
        end
    end

    assign o_data = w_gen_state ^ WIDTH'(r_inj_flip);
`else
    assign o_data = w_gen_state;
`endif

    // -------------------------------------------------------------- checker
    chk_state_t           r_state,     w_state_nxt;
    logic [WIDTH-1:0]     r_expected,  w_expected_nxt;
    logic [c_match_w-1:0] r_match_cnt, w_match_nxt;
    logic [c_miss_w-1:0]  r_miss_cnt,  w_miss_nxt;
    logic [ERR_W-1:0]     r_err_count, w_count_nxt;
    logic                 r_err,       w_err_nxt;
    logic                 r_lock;

    logic [WIDTH-1:0] w_exp_step;
    logic [WIDTH-1:0] w_data_step;
    logic             w_hit;
    logic             w_data_nz;

    assign w_exp_step  = WIDTH'(prbs_step(64'(r_expected), POLY, WIDTH));
    assign w_data_step = WIDTH'(prbs_step(64'(i_chk_data), POLY, WIDTH));
    assign w_hit       = (i_chk_data == r_expected);
    assign w_data_nz   = (i_chk_data != '0);

    always_comb begin
        w_state_nxt    = r_state;
        w_expected_nxt = r_expected;
        w_match_nxt    = r_match_cnt;
        w_miss_nxt     = r_miss_cnt;
        w_count_nxt    = r_err_count;
        w_err_nxt      = 1'b0;

        if (!i_enable) begin
            w_state_nxt = HUNT;
            w_match_nxt = '0;
            w_miss_nxt  = '0;
        end else if (i_chk_valid) begin
            case (r_state)
                HUNT: begin
                    // A zero word can never appear in the sequence; skip it.
                    if (w_data_nz) begin
                        w_expected_nxt = w_data_step;
                        w_match_nxt    = '0;
                        w_state_nxt    = SYNC;
                    end
                end
                SYNC: begin
                    if (w_hit) begin
                        w_expected_nxt = w_exp_step;
                        if (r_match_cnt == c_match_max) begin
                            w_state_nxt = LOCKED;
                            w_match_nxt = '0;
                        end else begin
                            w_match_nxt = r_match_cnt + c_match_w'(1);
                        end
                    end else begin
                        // Re-seed from the offending word rather than waiting
                        w_match_nxt = '0;
                        if (w_data_nz) begin
                            w_expected_nxt = w_data_step;
                        end else begin
                            w_state_nxt = HUNT;
                        end
                    end
                end
                LOCKED: begin
                    // Keep predicting through errors so single-word
                    // corruption does not cost synchronisation.
                    w_expected_nxt = w_exp_step;
                    if (!w_hit) begin
                        w_err_nxt = 1'b1;
                        if (r_err_count != {ERR_W{1'b1}}) begin
                            w_count_nxt = r_err_count + ERR_W'(1);
                        end
                        if (r_miss_cnt == c_miss_max) begin
                            w_state_nxt = HUNT;
                            w_miss_nxt  = '0;
                        end else begin
                            w_miss_nxt = r_miss_cnt + c_miss_w'(1);
                        end
                    end else begin
                        w_miss_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                end
            endcase
        end

        if (i_err_clr) begin
            w_count_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= HUNT;
            r_expected  <= '0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            r_err_count <= '0;
            r_err       <= 1'b0;
            r_lock      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_expected  <= w_expected_nxt;
            r_match_cnt <= w_match_nxt;
            r_miss_cnt  <= w_miss_nxt;
            r_err_count <= w_count_nxt;
            r_err       <= w_err_nxt;
            r_lock      <= (w_state_nxt == LOCKED);
        end
    end

    assign o_chk_lock  = r_lock;
    assign o_err       = r_err;
    assign o_err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_sdram_prbs_gen_check.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_prbs_gen_check
// Description : Directed self-checking bench for sdram_prbs_gen_check. Two
//               instances share the stimulus: the default build and one with
//               a 2-bit error counter for the saturation case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_prbs_gen_check;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       pause;
    logic       load;
    logic [7:0] ldata;
    logic       chk_valid;
    logic [7:0] chk_data;
    logic       err_clr;
`ifdef SDRAM_PRBS_ERR_INJECT_EN
    logic       inj;
`endif

    logic [7:0]  data,  data2;
    logic        lock,  lock2;
    logic        err,   err2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] m;
    logic       err_seen;
    logic       data_bad;

    always #5 clk = ~clk;

    sdram_prbs_gen_check u_dut (
        .clk         (clk),
        .reset       (reset),
`ifdef SDRAM_PRBS_ERR_INJECT_EN
        .i_inj       (inj),
`endif
        .i_enable    (enable),
        .i_pause     (pause),
        .i_load      (load),
        .i_ldata     (ldata),
        .o_data      (data),
        .i_chk_valid (chk_valid),
        .i_chk_data  (chk_data),
        .i_err_clr   (err_clr),
        .o_chk_lock  (lock),
        .o_err       (err),
        .o_err_count (cnt)
    );

    sdram_prbs_gen_check #(.ERR_W(2)) u_dut2 (
        .clk         (clk),
        .reset       (reset),
`ifdef SDRAM_PRBS_ERR_INJECT_EN
        .i_inj       (inj),
`endif
        .i_enable    (enable),
        .i_pause     (pause),
        .i_load      (load),
        .i_ldata     (ldata),
        .o_data      (data2),
        .i_chk_valid (chk_valid),
        .i_chk_data  (chk_data),
        .i_err_clr   (err_clr),
        .o_chk_lock  (lock2),
        .o_err       (err2),
        .o_err_count (cnt2)
    );

    // Reference sequence: x^8+x^4+x^3+x^2+1 Galois LFSR
    function automatic logic [7:0] tb_step(input logic [7:0] s);
        return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present the next stream word (optionally corrupted) and advance
    task automatic word(input logic [7:0] xm);
        chk_data  = m ^ xm;
        chk_valid = 1'b1;
        tick();
        m = tb_step(m);
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b1;
        pause     = 1'b0;
        load      = 1'b0;
        ldata     = 8'h00;
        chk_valid = 1'b0;
        chk_data  = 8'h00;
        err_clr   = 1'b0;
`ifdef SDRAM_PRBS_ERR_INJECT_EN
        inj       = 1'b0;
`endif
        tick();
        tick();
        check("reset_data", data, 8'h20);
        check("reset_lock", lock, 1'b0);
        check("reset_err",  err,  1'b0);
        check("reset_cnt",  cnt,  16'd0);

        // Generator free-run from the seed
        reset = 1'b0;
        check("gen_0", data, 8'h20);
        tick(); check("gen_1", data, 8'h40);
        tick(); check("gen_2", data, 8'h80);
        tick(); check("gen_3", data, 8'h1D);
        tick(); check("gen_4", data, 8'h3A);

        // Zero load substitutes the seed, then pause holds
        load = 1'b1; ldata = 8'h00;
        tick(); check("load_zero", data, 8'h20);
        load = 1'b0; pause = 1'b1;
        tick(); check("pause_1", data, 8'h20);
        tick(); check("pause_2", data, 8'h20);
        tick(); check("pause_3", data, 8'h20);
        pause = 1'b0;
        // Disable has priority over load
        enable = 1'b0; load = 1'b1; ldata = 8'h5A;
        tick(); check("disable_over_load", data, 8'h20);
        load = 1'b0;
        // Nonzero load value is taken as-is
        enable = 1'b1; load = 1'b1; ldata = 8'h5A;
        tick(); check("load_5a", data, 8'h5A);
        load = 1'b0; enable = 1'b0;
        tick(); check("disable_seed", data, 8'h20);

        // Loop-back stream: 1 HUNT word + 4 SYNC matches to lock
        enable = 1'b1;
        m = 8'h20;
        for (int i = 0; i < 4; i++) word(8'h00);
        check("lock_early", lock, 1'b0);
        word(8'h00);
        check("lock_rise", lock, 1'b1);
        check("gen_tracks", data, m);

        err_seen = 1'b0;
        data_bad = 1'b0;
        for (int i = 0; i < 995; i++) begin
            word(8'h00);
            err_seen = err_seen | err;
            data_bad = data_bad | (data !== m);
        end
        check("long_err_pulse", err_seen, 1'b0);
        check("long_gen", data_bad, 1'b0);
        check("long_cnt", cnt, 16'd0);
        check("long_lock", lock, 1'b1);

        // Single corrupted word
        word(8'h01);
        check("single_err", err, 1'b1);
        check("single_cnt", cnt, 16'd1);
        check("single_lock", lock, 1'b1);
        word(8'h00);
        check("single_err_drop", err, 1'b0);
        check("single_cnt_keep", cnt, 16'd1);
        err_clr = 1'b1;
        word(8'h00);
        err_clr = 1'b0;
        check("clr_cnt", cnt, 16'd0);

        // Clear wins over a same-cycle increment
        err_clr = 1'b1;
        word(8'h01);
        err_clr = 1'b0;
        check("clr_prio_err", err, 1'b1);
        check("clr_prio_cnt", cnt, 16'd0);
        word(8'h00);

        // Invalid cycle: checker and generator both hold
        chk_valid = 1'b0; chk_data = 8'hFF; pause = 1'b1;
        tick();
        pause = 1'b0;
        check("hold_err", err, 1'b0);
        check("hold_lock", lock, 1'b1);
        check("hold_data", data, m);
        word(8'h00);
        check("hold_resume_err", err, 1'b0);

        // Three consecutive misses drop lock
        word(8'h01);
        word(8'h01);
        check("miss2_lock", lock, 1'b1);
        word(8'h01);
        check("miss3_lock", lock, 1'b0);
        check("miss3_cnt", cnt, 16'd3);
        check("miss3_cnt2", cnt2, 2'd3);

        // Relock on the good stream after 5 words
        for (int i = 0; i < 4; i++) word(8'h00);
        check("relock_early", lock, 1'b0);
        word(8'h00);
        check("relock", lock, 1'b1);

        // Saturation: 5 spaced misses
        err_clr = 1'b1;
        word(8'h00);
        err_clr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            word(8'h01);
            word(8'h00);
        end
        check("sat_cnt2", cnt2, 2'd3);
        check("sat_cnt", cnt, 16'd5);
        check("sat_lock", lock, 1'b1);

        // Disable: checker to HUNT, count kept, generator to seed
        chk_valid = 1'b0;
        enable = 1'b0;
        tick();
        check("dis_cnt", cnt, 16'd5);
        check("dis_lock", lock, 1'b0);
        check("dis_data", data, 8'h20);

        // Relock, then reset mid-lock
        enable = 1'b1;
        m = 8'h20;
        for (int i = 0; i < 5; i++) word(8'h00);
        check("relock2", lock, 1'b1);
        reset = 1'b1;
        chk_valid = 1'b0;
        tick();
        check("rst_lock", lock, 1'b0);
        check("rst_cnt", cnt, 16'd0);
        check("rst_cnt2", cnt2, 2'd0);
        check("rst_data", data, 8'h20);
        check("rst_err", err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
